// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the I-cache and D-cache, one line in flight.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed D-over-I priority.

module mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_read,
  input  logic [ADDR_WIDTH-1:0] ic_address,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_resp,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [ADDR_WIDTH-1:0] dc_address,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  req_i, req_d, pick_d;
  logic                  grant_i, grant_d, capture;
  logic                  write_next, read_d, write_d;
  logic                  op_write_q;
  logic [LINE_WIDTH-1:0] line_q;

  // A simultaneous dc_read/dc_write is served as a write.
  assign req_i = ic_read;
  assign req_d = dc_read | dc_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;  // 1: the most recent grant went to the D side

  assign pick_d = req_d & (~req_i | ~last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d_q <= grant_d;
    end
  end
`else
  // The MEM-stage request is the older instruction, so D wins every tie.
  assign pick_d = req_d;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end else if (req_i) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          capture = 1'b1;
          state_d = DONE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          capture = 1'b1;
          state_d = DONE_D;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they rise on the grant edge itself.
    write_next = grant_d ? dc_write : op_write_q;
    read_d     = (state_d == SERVE_I) || ((state_d == SERVE_D) && !write_next);
    write_d    = (state_d == SERVE_D) && write_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the line buffer is reset along with the control state because its value is visible on rdata.
    if (!rst_n) begin
      state_q      <= IDLE;
      op_write_q   <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      ic_resp      <= 1'b0;
      dc_resp      <= 1'b0;
      line_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pmem_read  <= read_d;
      pmem_write <= write_d;
      ic_resp    <= (state_d == DONE_I);
      dc_resp    <= (state_d == DONE_D);
      if (grant_d) begin
        pmem_address <= dc_address;
        pmem_wdata   <= dc_wdata;
        op_write_q   <= dc_write;
      end else if (grant_i) begin
        pmem_address <= ic_address;
        op_write_q   <= 1'b0;
      end
      if (capture) begin
        line_q <= pmem_rdata;
      end
    end
  end

  // Both requesters see the same buffer; only their own resp qualifies it.
  assign ic_rdata = line_q;
  assign dc_rdata = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// Compile with ARB_ROUND_ROBIN_EN defined to check the alternating tie policy.

module tb_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst_n;
  logic          ic_read, ic_resp;
  logic [AW-1:0] ic_address;
  logic [LW-1:0] ic_rdata;
  logic          dc_read, dc_write, dc_resp;
  logic [AW-1:0] dc_address;
  logic [LW-1:0] dc_wdata, dc_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_read      (ic_read),
    .ic_address   (ic_address),
    .ic_rdata     (ic_rdata),
    .ic_resp      (ic_resp),
    .dc_read      (dc_read),
    .dc_write     (dc_write),
    .dc_address   (dc_address),
    .dc_wdata     (dc_wdata),
    .dc_rdata     (dc_rdata),
    .dc_resp      (dc_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) assert (!(dc_read && dc_write)) else $error("dc_read and dc_write both high");
  end

  // ---------------- memory model ----------------
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            stable;
  } pm_t;

  int            mem_lat = 4;
  pm_t           pm_log[$];
  logic [LW-1:0] mem[logic [AW-1:0]];
  logic [LW-1:0] ref_mem[logic [AW-1:0]];

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
  endfunction

  // Memory answers mem_lat cycles after it first sees a strobe; logs what it saw.
  initial begin : mem_model
    int            cnt;
    bit            stab, wr0;
    logic [AW-1:0] a0;
    logic [LW-1:0] w0;
    cnt = 0; stab = 1'b0; wr0 = 1'b0; a0 = '0; w0 = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst_n || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          a0 = pmem_address; w0 = pmem_wdata; wr0 = pmem_write; stab = 1'b1;
        end else if (pmem_address !== a0 || pmem_wdata !== w0 || pmem_write !== wr0) begin
          stab = 1'b0;
        end
        if (pmem_read === pmem_write) stab = 1'b0;
        if (cnt >= mem_lat) begin
          pm_log.push_back('{wr: wr0, addr: a0, wdata: w0, stable: stab});
          if (wr0) begin
            mem[a0]    = w0;
            pmem_rdata = {8{$urandom()}};
          end else begin
            pmem_rdata = mem.exists(a0) ? mem[a0] : default_line(a0);
          end
          pmem_resp = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // ---------------- arbitration model ----------------
  bit last_d = 1'b0;

  function automatic bit tie_goes_d();
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, " pmem_read"},    LW'(pmem_read),    '0);
    check({tag, " pmem_write"},   LW'(pmem_write),   '0);
    check({tag, " pmem_address"}, LW'(pmem_address), '0);
    check({tag, " pmem_wdata"},   pmem_wdata,        '0);
    check({tag, " ic_resp"},      LW'(ic_resp),      '0);
    check({tag, " dc_resp"},      LW'(dc_resp),      '0);
    check({tag, " ic_rdata"},     ic_rdata,          '0);
    check({tag, " dc_rdata"},     dc_rdata,          '0);
  endtask

  // One request round: caches raise requests together, hold until resp, drop on resp.
  task automatic run_txn(input string name, input bit i_en, input bit d_en, input bit d_wr,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [LW-1:0] dw, input bit scramble, input bit drop_i);
    bit            order[$];
    bit            i_done, d_done;
    int            cyc, i_lat, d_lat, i_pulses, d_pulses, i_idx, d_idx;
    logic [LW-1:0] i_exp, d_exp, i_got, d_got;

    i_exp = '0; d_exp = '0; i_got = '0; d_got = '0;
    i_lat = 0; d_lat = 0; i_pulses = 0; d_pulses = 0; i_idx = 0; d_idx = 0;
    if (d_en && (!i_en || tie_goes_d())) begin
      order.push_back(1'b1);
      if (i_en) order.push_back(1'b0);
    end else begin
      if (i_en) order.push_back(1'b0);
      if (d_en) order.push_back(1'b1);
    end
    foreach (order[k]) begin
      if (order[k]) begin
        d_idx = k;
        if (d_wr) ref_mem[da] = dw;
        else      d_exp = ref_read(da);
        last_d = 1'b1;
      end else begin
        i_idx = k;
        i_exp = ref_read(ia);
        last_d = 1'b0;
      end
    end

    pm_log.delete();
    @(negedge clk);
    ic_read = i_en;  ic_address = ia;
    dc_read = d_en && !d_wr;  dc_write = d_en && d_wr;
    dc_address = da; dc_wdata = dw;
    i_done = !i_en; d_done = !d_en; cyc = 0;
    while (!(i_done && d_done) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (drop_i && cyc == 2) ic_read = 1'b0;
      if (scramble && !d_done) begin
        dc_wdata   = {8{$urandom()}};
        dc_address = $urandom() & 32'hFFFF_FFE0;
      end
      if (ic_resp) begin
        i_pulses++; i_got = ic_rdata; i_lat = cyc + 1; i_done = 1'b1; ic_read = 1'b0;
      end
      if (dc_resp) begin
        d_pulses++; d_got = dc_rdata; d_lat = cyc + 1; d_done = 1'b1;
        dc_read = 1'b0; dc_write = 1'b0;
      end
    end
    check({name, " timeout"}, LW'(cyc < 400), LW'(1));
    repeat (3) begin
      @(negedge clk);
      if (ic_resp) i_pulses++;
      if (dc_resp) d_pulses++;
    end

    check({name, " ic_resp pulses"}, LW'(i_pulses), LW'(i_en));
    check({name, " dc_resp pulses"}, LW'(d_pulses), LW'(d_en));
    if (i_en) begin
      check({name, " ic latency"}, LW'(i_lat), LW'(i_idx == 0 ? mem_lat + 2 : 2 * mem_lat + 4));
      check({name, " ic_rdata"}, i_got, i_exp);
    end
    if (d_en) begin
      check({name, " dc latency"}, LW'(d_lat), LW'(d_idx == 0 ? mem_lat + 2 : 2 * mem_lat + 4));
      if (!d_wr) check({name, " dc_rdata"}, d_got, d_exp);
    end
    check({name, " pmem txn count"}, LW'(pm_log.size()), LW'(order.size()));
    foreach (order[k]) begin
      if (k < pm_log.size()) begin
        check($sformatf("%s txn%0d write", name, k), LW'(pm_log[k].wr), LW'(order[k] && d_wr));
        check($sformatf("%s txn%0d address", name, k), LW'(pm_log[k].addr), LW'(order[k] ? da : ia));
        check($sformatf("%s txn%0d stable", name, k), LW'(pm_log[k].stable), LW'(1));
        if (order[k] && d_wr) check($sformatf("%s txn%0d wdata", name, k), pm_log[k].wdata, dw);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    rst_n = 1'b0;
    ic_read = 1'b0; ic_address = '0;
    dc_read = 1'b0; dc_write = 1'b0; dc_address = '0; dc_wdata = '0;
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    mem_lat = 4;
    mem[32'h60]     = {32{8'hA5}};
    ref_mem[32'h60] = {32{8'hA5}};
    run_txn("i_read", 1'b1, 1'b0, 1'b0, 32'h60, '0, '0, 1'b0, 1'b0);
    run_txn("d_writeback", 1'b0, 1'b1, 1'b1, '0, 32'h1000, {8{32'h1234_5678}}, 1'b1, 1'b0);
    run_txn("d_readback", 1'b0, 1'b1, 1'b0, '0, 32'h1000, '0, 1'b0, 1'b0);
    run_txn("tie", 1'b1, 1'b1, 1'b0, 32'h200, 32'h300, '0, 1'b0, 1'b0);

    run_txn("pre_d_grant", 1'b0, 1'b1, 1'b0, '0, 32'h400, '0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_txn($sformatf("tie_round%0d", r), 1'b1, 1'b1, (r == 1),
              32'h440 + 32'(r * 32), 32'h4A0 + 32'(r * 32), {8{32'hBEEF_0000 + 32'(r)}}, 1'b0, 1'b0);
    end

    run_txn("abandon", 1'b1, 1'b0, 1'b0, 32'h520, '0, '0, 1'b0, 1'b1);

    // Reset in the middle of an I-cache fill.
    @(negedge clk);
    ic_read = 1'b1; ic_address = 32'h800;
    @(negedge clk);
    @(negedge clk);
    check("midrst strobe before reset", LW'(pmem_read), LW'(1));
    #2;
    rst_n = 1'b0;
    ic_read = 1'b0;
    #1;
    check_outputs_zero("midrst");
    last_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst idle after release", LW'(pmem_read | pmem_write), '0);
    run_txn("post_reset", 1'b1, 1'b0, 1'b0, 32'h820, '0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      int            kind;
      bit            ie, de, dwr;
      logic [AW-1:0] ia, da;
      mem_lat = $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      ie   = (kind != 1);
      de   = (kind != 0);
      dwr  = 1'($urandom_range(0, 1));
      ia   = 32'($urandom_range(0, 15)) << 5;
      da   = 32'($urandom_range(0, 15)) << 5;
      run_txn($sformatf("rand%0d", n), ie, de, dwr, ia, da, {8{$urandom()}}, de && !ie, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single physical memory port between the instruction cache (fetch side) and the data cache (MEM-stage side) of the pipelined RV32I core. One line transaction is in flight at a time. The block latches the winning request, drives the physical memory, buffers the returned line, and returns a one-cycle response to the winner. It sits between the two caches and main memory.

## Interface
- `LINE_WIDTH`, default 256: cache line width in bits.
- `ADDR_WIDTH`, default 32: byte address width; line-aligned addresses pass through unmodified.
- `clk` input 1: the block's one clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ic_read` input 1: I-cache line read request, level, held until `ic_resp`.
- `ic_address` input ADDR_WIDTH: I-cache line address.
- `ic_rdata` output LINE_WIDTH: line returned to the I-cache, valid while `ic_resp`=1.
- `ic_resp` output 1: one-cycle completion pulse to the I-cache.
- `dc_read` input 1: D-cache line read request (fill).
- `dc_write` input 1: D-cache line write request (writeback); mutually exclusive with `dc_read`.
- `dc_address` input ADDR_WIDTH: D-cache line address.
- `dc_wdata` input LINE_WIDTH: writeback line.
- `dc_rdata` output LINE_WIDTH: line returned to the D-cache, valid while `dc_resp`=1.
- `dc_resp` output 1: one-cycle completion pulse to the D-cache.
- `pmem_read` output 1: physical memory read, held until `pmem_resp`.
- `pmem_write` output 1: physical memory write, held until `pmem_resp`.
- `pmem_address` output ADDR_WIDTH: latched transaction address.
- `pmem_wdata` output LINE_WIDTH: latched writeback line.
- `pmem_rdata` input LINE_WIDTH: read line, valid with `pmem_resp`.
- `pmem_resp` input 1: memory completion, one cycle.

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- IDLE: arbitrate on the current requests.
  - Only `ic_read` asserted: latch `ic_address` and go to SERVE_I.
  - `dc_read` or `dc_write` asserted: latch `dc_address`, `dc_wdata`, and the op, then go to SERVE_D.
  - Both sides requesting: D wins, because the MEM-stage request is the older instruction.
- SERVE_x: drive `pmem_read`/`pmem_write` and `pmem_address`/`pmem_wdata` from the latches.
  - On `pmem_resp`, capture `pmem_rdata` into the line buffer and go to DONE_x.
- DONE_x: assert `x_resp` for exactly one cycle, with `x_rdata` equal to the buffer, then go to IDLE.
  - For a D write, `dc_rdata` is don't-care.
- Requester inputs are sampled only in IDLE. Changes during SERVE_x and DONE_x are ignored.
- Requester drops its request mid-transaction: the memory transaction still completes and `x_resp` still pulses. There is no abort.
- `dc_read` and `dc_write` both high: treated as write; a bench assertion flags it.
- `ic_rdata` and `dc_rdata` both come from the same buffer; only the addressed `resp` qualifies it.

## Timing
- Reset values (asynchronous, immediate): state IDLE.
  - All outputs 0: `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `ic_resp`, `dc_resp`.
  - `ic_rdata`, `dc_rdata`, and the buffer are 0.
- Reset asserted mid-transaction: pmem strobes drop in the same cycle and the transaction is lost. Memory must also be reset.
- All outputs are registered from state and latches; there is no combinational input-to-output path.
- Latency:
  - Request seen in IDLE at edge E0 → pmem strobe high from E0 to the edge after `pmem_resp`.
  - `pmem_resp` sampled at edge En → `x_resp` high for cycle En..En+1.
  - Back in IDLE at En+1; the earliest next pmem strobe is after edge En+2.
- Total requester latency = memory latency + 2 cycles.
- Minimum spacing between `x_resp` pulses is 3 cycles.
- A requester that still holds its request in the IDLE cycle after `resp` starts a new transaction. Caches must drop the request on `resp`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: one-bit last-grant register, reset to I.
  - On a tie in IDLE, the side not granted last wins.
  - Single-requester cases are unchanged.
- `ARB_ROUND_ROBIN_EN` undefined: fixed D-over-I priority; the last-grant register is not present.

## Test plan
- **Reset:** `rst_n`=0 while SERVE_I with `pmem_read`=1 → `pmem_read` drops before the next edge; all outputs 0; state IDLE.
- **I-read:** `ic_read`, `ic_address`=0x0000_0060, memory latency 4, `pmem_rdata`=0xA5…A5 → `pmem_address`=0x60; `ic_resp` is one cycle, 6 cycles after the request; `ic_rdata`=0xA5…A5; `dc_resp` stays 0.
- **D writeback:**
  - Stimulus: `dc_write`, `dc_address`=0x0000_1000, `dc_wdata`=0x1234…; `dc_wdata` changed during SERVE_D.
  - Required: `pmem_write`=1 and `pmem_wdata` holds the original value throughout; one `dc_resp`.
- **Simultaneous requests, fixed priority:** `ic_read` and `dc_read` in the same IDLE cycle → D served first, then I in a second transaction; `ic_resp` strictly after `dc_resp`.
- **Simultaneous requests, `ARB_ROUND_ROBIN_EN`:** three back-to-back tie rounds, with last grant D → grant order I, D, I.
- **Abandon:** `ic_read` dropped in the cycle after SERVE_I is entered → memory transaction completes; one `ic_resp` pulse; arbiter returns to IDLE.
